element_wise_out_packer: RTL and testbench
==========================================

# element_wise_out_packer

Downstream neighbour of `element_wise_out_data_cvt_cell`. It takes the per-element converted results (S33 fixed point or FP32), saturates fixed-point results to INT8 or INT16 when requested, and packs elements into 32-bit words. It buffers the words in a small FIFO and emits them on an AXI-Stream master with keep/last. Upstream has no ready signal, so this block provides a stall signal that the parent uses to drop the conversion pipeline's `aclken`.

## Interface
- `SIM_DELAY`, 1: simulation-only register delay.
- `INFO_ALONG_WIDTH`, 2: side-band width from the convert cell; bit 0 is the end-of-row flag.
- `FIFO_DEPTH`, 8: output word FIFO depth, power of 2, ≥ 4.
- `STALL_MARGIN`, 4: `pack_stall` asserts when free FIFO entries < `STALL_MARGIN`.

Ports (clock and reset first):
- `aclk` in 1: clock.
- `areset` in 1: asynchronous, active-high reset.
- `pack_fmt` in 2: 2'b00 INT8, 2'b01 INT16, 2'b10 FP32 passthrough; 2'b11 is treated as FP32. Changed only when idle.
- `pack_i_res` in 33: S33 signed value, or FP32 in bits [31:0] when `pack_fmt` is FP32.
- `pack_i_info_along` in `INFO_ALONG_WIDTH`: bit 0 is end-of-row.
- `pack_i_vld` in 1: element valid; no ready, always accepted.
- `pack_stall` out 1: request for upstream clock-enable low.
- `m_axis_data` out 32, `m_axis_keep` out 4, `m_axis_last` out 1, `m_axis_valid` out 1, `m_axis_ready` in 1: output stream.
- `pack_idle` out 1: stages empty, pack count 0, FIFO empty.
- `ovf_err` out 1: sticky FIFO overflow; cleared only by reset.

## Operation
- Stage S (saturate), registered:
  - INT8: clamp to [-128, 127] and keep 8 bits.
  - INT16: clamp to [-32768, 32767] and keep 16 bits.
  - FP32: pass bits [31:0] unchanged.
  - Registered along with the last flag and a valid bit.
- Stage P (pack):
  - Lanes per word L = 4 (INT8), 2 (INT16), 1 (FP32).
  - Element k of a word occupies lane k; lane 0 is the lowest bits.
  - Counter `cnt` runs 0..L-1. Data lanes are written with the element; keep bits for each written lane are set to 1 (bytes per lane).
  - A word completes when `cnt` reaches L-1 or the element carries last.
  - On completion, push {data, keep, last} into the FIFO, then clear `cnt`, the accumulator and keep.
  - Unused lanes of a partial word are 0 with keep 0.
- FIFO: first-word-fall-through; its head drives `m_axis_*`. Pop on `m_axis_valid && m_axis_ready`.
- Push and pop in the same cycle on a full FIFO: both happen and there is no overflow.
- Push when full and not popping: the word is dropped, `ovf_err` is set, and the FIFO state is unchanged.
- `pack_stall` = (free entries < `STALL_MARGIN`), combinational from the registered FIFO count.
- An element is never split across words. FP32 words always have keep 4'hF.

## Timing
- Reset values:
  - All counters, valids, FIFO pointers and `ovf_err` are 0.
  - `m_axis_valid` = 0, `m_axis_data` = 0, `m_axis_keep` = 0, `m_axis_last` = 0.
  - `pack_stall` = 0, `pack_idle` = 1.
- Latency with the FIFO empty: the element that completes a word, valid in cycle t, gives `m_axis_valid`=1 in cycle t+2.
- Throughput: 1 element/cycle in; up to 1 word/cycle out.
- `m_axis_valid` holds once asserted and data is stable until ready (AXIS rule).
- Reset mid-operation discards any partial word and all FIFO contents immediately (asynchronous).

## Structure
- Package `element_wise_pkg`:
  - Format codes `PACK_FMT_INT8`, `PACK_FMT_INT16`, `PACK_FMT_FP32`.
  - INT8/INT16 min/max constants.
  - Typedef `pack_word_t` {data[31:0], keep[3:0], last}.
- Sub-module `element_wise_pack_fifo`: synchronous FWFT FIFO of `pack_word_t`, with count output and full/empty flags.

## Test plan
- INT8: inputs 5, -3, 200, -300 (no last), ready=1 → one word, data 32'h80_7F_FD_05, keep 4'hF, last 0, at t+2 after the 4th element.
- INT16: 40000 then -7 with last → data 32'hFFF9_7FFF, keep 4'hF, last 1. Then 12 alone with last → data 32'h0000_000C, keep 4'h3, last 1.
- FP32: inputs 0x3FCCCCCD then 0xC0000000 → two words passed bit-exact, keep 4'hF.
- INT8: 3 elements with last on the 3rd → keep 4'h7, lane 3 data 0, last 1.
- Backpressure with `m_axis_ready`=0 and FP32:
  - `pack_stall` rises when the 5th word enters the FIFO (DEPTH 8, MARGIN 4).
  - The 9th word sets `ovf_err`; the first 8 words drain intact and in order once ready=1.
- Assert `areset` with 2 words buffered and a partial INT8 word → `m_axis_valid` drops immediately and `pack_idle`=1. The next 4 elements form a fresh word.

Source files
------------

// File: rtl/element_wise_pkg.sv
// Shared types and constants for the element-wise output packer.
// Format codes, saturation limits and the packed output word.
package element_wise_pkg;

    localparam logic [1:0] PACK_FMT_INT8  = 2'b00;
    localparam logic [1:0] PACK_FMT_INT16 = 2'b01;
    localparam logic [1:0] PACK_FMT_FP32  = 2'b10;

    localparam logic signed [32:0] INT8_MIN  = -33'sd128;
    localparam logic signed [32:0] INT8_MAX  = 33'sd127;
    localparam logic signed [32:0] INT16_MIN = -33'sd32768;
    localparam logic signed [32:0] INT16_MAX = 33'sd32767;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } pack_word_t;

    // Clamp an S33 value to the lane width, or pass FP32 bits through.
    function automatic logic [31:0] sat_elem(
        input logic [1:0]         fmt,
        input logic signed [32:0] res
    );
        logic [31:0] r;
        r = '0;
        unique case (1'b1)
            (fmt == PACK_FMT_INT8): begin
                if (res > INT8_MAX)
                    r[7:0] = 8'h7F;
                else if (res < INT8_MIN)
                    r[7:0] = 8'h80;
                else
                    r[7:0] = res[7:0];
            end
            (fmt == PACK_FMT_INT16): begin
                if (res > INT16_MAX)
                    r[15:0] = 16'h7FFF;
                else if (res < INT16_MIN)
                    r[15:0] = 16'h8000;
                else
                    r[15:0] = res[15:0];
            end
            default: r = res[31:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/element_wise_pack_fifo.sv
// First-word-fall-through FIFO of packed output words.
// A push into a full FIFO without a pop is dropped and flagged.
module element_wise_pack_fifo
    import element_wise_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  pack_word_t               wr_word,
    input  logic                     pop,
    output pack_word_t               rd_word,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);

    pack_word_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovf     = push && full && !do_pop;
    assign rd_word = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are qualified by count so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_word;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/element_wise_out_packer.sv
// Saturates converted elements, packs them into 32-bit words and
// streams them out over AXI-Stream with a stall back to the pipeline.
module element_wise_out_packer
    import element_wise_pkg::*;
#(
    parameter int SIM_DELAY        = 1,
    parameter int INFO_ALONG_WIDTH = 2,
    parameter int FIFO_DEPTH       = 8,
    parameter int STALL_MARGIN     = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [1:0]                  pack_fmt,
    input  logic signed [32:0]          pack_i_res,
    input  logic [INFO_ALONG_WIDTH-1:0] pack_i_info_along,
    input  logic                        pack_i_vld,
    output logic                        pack_stall,
    output logic [31:0]                 m_axis_data,
    output logic [3:0]                  m_axis_keep,
    output logic                        m_axis_last,
    output logic                        m_axis_valid,
    input  logic                        m_axis_ready,
    output logic                        pack_idle,
    output logic                        ovf_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 4 || STALL_MARGIN > FIFO_DEPTH || SIM_DELAY < 0)
    begin : g_param_err
        $error("element_wise_out_packer: bad parameters");
    end

    logic          s_vld;
    logic [31:0]   s_data;
    logic          s_last;

    logic [1:0]    cnt;
    logic [31:0]   acc;
    logic [3:0]    keep;

    logic [1:0]    lanes_m1;
    logic [31:0]   word_acc;
    logic [3:0]    word_keep;
    logic          word_done;

    pack_word_t    push_word;
    pack_word_t    head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_ovf;
    logic [CW-1:0] free_cnt;

    logic          unused_info;
    logic          unused_full;

    assign unused_info = ^pack_i_info_along;
    assign unused_full = fifo_full;

    // Stage S: saturate and register each element with its row-end flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_vld  <= 1'b0;
            s_data <= '0;
            s_last <= 1'b0;
        end else begin
            s_vld <= pack_i_vld;
            if (pack_i_vld) begin
                s_data <= sat_elem(pack_fmt, pack_i_res);
                s_last <= pack_i_info_along[0];
            end
        end
    end

    // Stage P: merge the current element into the partial word.
    always_comb begin
        lanes_m1  = 2'd0;
        word_acc  = acc;
        word_keep = keep;
        unique case (1'b1)
            (pack_fmt == PACK_FMT_INT8): begin
                lanes_m1 = 2'd3;
                word_acc[{cnt, 3'b000} +: 8] = s_data[7:0];
                word_keep[cnt] = 1'b1;
            end
            (pack_fmt == PACK_FMT_INT16): begin
                lanes_m1 = 2'd1;
                word_acc[{cnt[0], 4'b0000} +: 16] = s_data[15:0];
                word_keep[{cnt[0], 1'b0} +: 2] = 2'b11;
            end
            default: begin
                lanes_m1  = 2'd0;
                word_acc  = s_data;
                word_keep = 4'hF;
            end
        endcase
        word_done = s_vld && ((cnt == lanes_m1) || s_last);
    end

    assign push_word.data = word_acc;
    assign push_word.keep = word_keep;
    assign push_word.last = s_last;

    // Stage P state: lane counter and the partially filled word.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt  <= '0;
            acc  <= '0;
            keep <= '0;
        end else if (s_vld) begin
            if (word_done) begin
                cnt  <= '0;
                acc  <= '0;
                keep <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
                acc  <= word_acc;
                keep <= word_keep;
            end
        end
    end

    element_wise_pack_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .push    (word_done),
        .wr_word (push_word),
        .pop     (m_axis_ready),
        .rd_word (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ovf     (fifo_ovf)
    );

    // Sticky overflow flag; only reset clears it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            ovf_err <= 1'b0;
        else if (fifo_ovf)
            ovf_err <= 1'b1;
    end

    assign free_cnt     = CW'(FIFO_DEPTH) - fifo_count;
    assign pack_stall   = (free_cnt < CW'(STALL_MARGIN));
    assign m_axis_valid = !fifo_empty;
    assign m_axis_data  = head.data;
    assign m_axis_keep  = head.keep;
    assign m_axis_last  = head.last;
    assign pack_idle    = !s_vld && (cnt == '0) && fifo_empty;

endmodule

// File: tb/tb_element_wise_out_packer.sv
// Randomized scoreboard bench for element_wise_out_packer.
// Expected words come from a lane-list model of the packing rules.
module tb_element_wise_out_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic               aclk = 1'b0;
    logic               areset = 1'b1;
    logic [1:0]         pack_fmt = 2'b00;
    logic signed [32:0] pack_i_res = '0;
    logic [1:0]         pack_i_info_along = '0;
    logic               pack_i_vld = 1'b0;
    logic               pack_stall;
    logic [31:0]        m_axis_data;
    logic [3:0]         m_axis_keep;
    logic               m_axis_last;
    logic               m_axis_valid;
    logic               m_axis_ready = 1'b0;
    logic               pack_idle;
    logic               ovf_err;

    int n_cmp = 0;
    int n_bad = 0;

    word_t       exp_q[$];
    logic [31:0] pend[$];
    logic        hold_v = 1'b0;
    word_t       hold_w;

    element_wise_out_packer #(
        .SIM_DELAY        (1),
        .INFO_ALONG_WIDTH (2),
        .FIFO_DEPTH       (8),
        .STALL_MARGIN     (4)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .pack_fmt          (pack_fmt),
        .pack_i_res        (pack_i_res),
        .pack_i_info_along (pack_i_info_along),
        .pack_i_vld        (pack_i_vld),
        .pack_stall        (pack_stall),
        .m_axis_data       (m_axis_data),
        .m_axis_keep       (m_axis_keep),
        .m_axis_last       (m_axis_last),
        .m_axis_valid      (m_axis_valid),
        .m_axis_ready      (m_axis_ready),
        .pack_idle         (pack_idle),
        .ovf_err           (ovf_err)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lanes_of(input logic [1:0] fmt);
        if (fmt == 2'b00) return 4;
        if (fmt == 2'b01) return 2;
        return 1;
    endfunction

    // Saturated lane value, computed with plain integer clamping.
    function automatic logic [31:0] lane_val(input logic [1:0] fmt,
                                             input logic signed [32:0] r);
        longint v;
        v = longint'(r);
        if (fmt == 2'b00) begin
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            return 32'(v) & 32'hFF;
        end
        if (fmt == 2'b01) begin
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            return 32'(v) & 32'hFFFF;
        end
        return r[31:0];
    endfunction

    // Reference model: gather lanes, emit a word when full or on last.
    task automatic model_add(input logic [1:0] fmt,
                             input logic signed [32:0] r,
                             input logic last);
        int    n;
        int    bytes;
        word_t w;
        n = lanes_of(fmt);
        bytes = 4 / n;
        pend.push_back(lane_val(fmt, r));
        if (pend.size() == n || last) begin
            w.data = '0;
            w.keep = '0;
            w.last = last;
            for (int k = 0; k < pend.size(); k++) begin
                w.data = w.data | (pend[k] << (k * bytes * 8));
                w.keep = w.keep | (4'((1 << bytes) - 1) << (k * bytes));
            end
            exp_q.push_back(w);
            pend.delete();
        end
    endtask

    task automatic send(input logic [1:0] fmt,
                        input logic signed [32:0] r,
                        input logic last);
        @(posedge aclk);
        #1;
        pack_fmt          = fmt;
        pack_i_res        = r;
        pack_i_info_along = {1'($urandom_range(0, 1)), last};
        pack_i_vld        = 1'b1;
        model_add(fmt, r, last);
    endtask

    task automatic idle_cyc();
        @(posedge aclk);
        #1;
        pack_i_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        m_axis_ready = 1'b1;
        idle_cyc();
        while ((exp_q.size() != 0 || !pack_idle) && b < 500) begin
            idle_cyc();
            b++;
        end
        check({name, "_drain"}, 64'(b < 500), 64'd1);
    endtask

    function automatic logic signed [32:0] rnd_res(input logic [1:0] fmt);
        logic [63:0] t;
        t = {$urandom, $urandom};
        if (fmt[1]) return t[32:0];
        unique case ($urandom_range(0, 3))
            0: return 33'(int'($urandom_range(0, 600)) - 300);
            1: return 33'(int'($urandom_range(0, 80000)) - 40000);
            2: return t[32:0];
            default: begin
                unique case ($urandom_range(0, 7))
                    0: return 33'sd127;
                    1: return 33'sd128;
                    2: return -33'sd128;
                    3: return -33'sd129;
                    4: return 33'sd32767;
                    5: return 33'sd32768;
                    6: return -33'sd32769;
                    default: return {1'b1, 32'h0};
                endcase
            end
        endcase
    endfunction

    // Monitor: compare every accepted beat and check AXIS stability.
    always @(negedge aclk) begin
        word_t e;
        if (areset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                check("axis_hold",
                      64'({m_axis_valid, m_axis_data, m_axis_keep, m_axis_last}),
                      64'({1'b1, hold_w}));
            if (m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(m_axis_data), 64'hDEAD_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("word",
                          64'({m_axis_data, m_axis_keep, m_axis_last}),
                          64'(e));
                end
            end
            hold_v = m_axis_valid && !m_axis_ready;
            hold_w = {m_axis_data, m_axis_keep, m_axis_last};
        end
    end

    initial begin
        logic [1:0] fmt;
        int         cnt;
        // Reset values.
        #2;
        check("rst_valid", 64'(m_axis_valid), 64'd0);
        check("rst_data",  64'(m_axis_data), 64'd0);
        check("rst_keep",  64'(m_axis_keep), 64'd0);
        check("rst_last",  64'(m_axis_last), 64'd0);
        check("rst_stall", 64'(pack_stall), 64'd0);
        check("rst_idle",  64'(pack_idle), 64'd1);
        check("rst_ovf",   64'(ovf_err), 64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        m_axis_ready = 1'b1;

        // INT8 saturation, packing and t+2 latency.
        send(2'b00, 33'sd5, 1'b0);
        send(2'b00, -33'sd3, 1'b0);
        send(2'b00, 33'sd200, 1'b0);
        send(2'b00, -33'sd300, 1'b0);
        idle_cyc();
        check("lat_t1_valid", 64'(m_axis_valid), 64'd0);
        idle_cyc();
        check("lat_t2_valid", 64'(m_axis_valid), 64'd1);
        check("int8_data", 64'(m_axis_data), 64'h807F_FD05);
        check("int8_keep", 64'(m_axis_keep), 64'hF);
        drain("int8");

        // INT16 with last, then a lone element with last.
        send(2'b01, 33'sd40000, 1'b0);
        send(2'b01, -33'sd7, 1'b1);
        send(2'b01, 33'sd12, 1'b1);
        drain("int16");

        // FP32 passthrough.
        send(2'b10, 33'h0_3FCC_CCCD, 1'b0);
        send(2'b10, 33'h0_C000_0000, 1'b0);
        drain("fp32");

        // INT8 partial word closed by last.
        send(2'b00, 33'sd1, 1'b0);
        send(2'b00, 33'sd2, 1'b0);
        send(2'b00, 33'sd3, 1'b1);
        drain("int8_part");

        // Backpressure: stall threshold and overflow.
        m_axis_ready = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            @(posedge aclk);
            #1;
            check($sformatf("stall_j%0d", j), 64'(pack_stall),
                  64'((j - 2) >= 5));
            check($sformatf("ovf_pre_j%0d", j), 64'(ovf_err), 64'd0);
            pack_fmt          = 2'b10;
            pack_i_res        = 33'(j * 32'h0101_0101);
            pack_i_info_along = '0;
            pack_i_vld        = 1'b1;
            model_add(2'b10, 33'(j * 32'h0101_0101), 1'b0);
        end
        void'(exp_q.pop_back());
        idle_cyc();
        idle_cyc();
        idle_cyc();
        check("ovf_set", 64'(ovf_err), 64'd1);
        check("stall_full", 64'(pack_stall), 64'd1);
        drain("ovf");
        check("ovf_sticky", 64'(ovf_err), 64'd1);

        // Asynchronous reset with buffered words and a partial word.
        m_axis_ready = 1'b0;
        for (int j = 0; j < 10; j++)
            send(2'b00, 33'(j), 1'b0);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        areset = 1'b1;
        #1;
        check("arst_valid", 64'(m_axis_valid), 64'd0);
        check("arst_idle", 64'(pack_idle), 64'd1);
        check("arst_ovf", 64'(ovf_err), 64'd0);
        exp_q.delete();
        pend.delete();
        @(posedge aclk);
        #1;
        areset = 1'b0;
        send(2'b00, 33'sd17, 1'b0);
        send(2'b00, -33'sd1, 1'b0);
        send(2'b00, 33'sd1000, 1'b0);
        send(2'b00, 33'sd64, 1'b0);
        drain("post_rst");

        // Random blocks, format changed only while idle.
        for (int blk = 0; blk < 12; blk++) begin
            fmt = 2'($urandom_range(0, 3));
            cnt = 0;
            while (cnt < 40) begin
                @(posedge aclk);
                #1;
                m_axis_ready = ($urandom_range(0, 9) < 7);
                if (pack_stall || $urandom_range(0, 4) == 0) begin
                    pack_i_vld = 1'b0;
                end else begin
                    pack_fmt          = fmt;
                    pack_i_res        = rnd_res(fmt);
                    pack_i_info_along = {1'($urandom_range(0, 1)),
                                         1'(cnt == 39 || $urandom_range(0, 7) == 0)};
                    pack_i_vld        = 1'b1;
                    model_add(fmt, pack_i_res, pack_i_info_along[0]);
                    cnt++;
                end
            end
            drain($sformatf("rnd%0d", blk));
        end

        check("end_queue", 64'(exp_q.size()), 64'd0);
        check("end_ovf", 64'(ovf_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
